// File: rtl/mul_array_arbiter.sv
// mul_array_arbiter: two-port round-robin front end for a single shared
// WIDTH x WIDTH -> 2*WIDTH array multiplier, with a one-deep registered
// result stage that supports backpressure.
// Optional feature: define MUL_ARB_SIGNED_EN to honour reqX_signed
// (two's complement operands); otherwise every operation is unsigned.

// Combinational array multiplier, exact unsigned 2*WIDTH product.
module mul_array #(
    parameter int WIDTH        = 8,
    parameter bit BEHAVIORAL   = 1'b0,
    parameter bit RIPPLE_CARRY = 1'b1
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    localparam int PW = 2 * WIDTH;

    generate
        if (BEHAVIORAL) begin : g_behav
            assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end else begin : g_array
            logic [PW-1:0] pp [WIDTH];
            genvar gi;
            // One shifted partial product per multiplier bit.
            for (gi = 0; gi < WIDTH; gi++) begin : g_pp
                assign pp[gi] = b[gi] ? ({{WIDTH{1'b0}}, a} << gi) : '0;
            end
            if (RIPPLE_CARRY) begin : g_ripple
                // Single linear accumulation chain over all rows.
                logic [PW-1:0] acc [WIDTH+1];
                assign acc[0] = '0;
                for (gi = 0; gi < WIDTH; gi++) begin : g_acc
                    assign acc[gi+1] = acc[gi] + pp[gi];
                end
                assign p = acc[WIDTH];
            end else begin : g_split
                // Even and odd rows accumulate in parallel, then merge,
                // halving the depth of the adder chain.
                logic [PW-1:0] ev [WIDTH+1];
                logic [PW-1:0] od [WIDTH+1];
                assign ev[0] = '0;
                assign od[0] = '0;
                for (gi = 0; gi < WIDTH; gi++) begin : g_acc
                    if (gi % 2 == 0) begin : g_even
                        assign ev[gi+1] = ev[gi] + pp[gi];
                        assign od[gi+1] = od[gi];
                    end else begin : g_odd
                        assign ev[gi+1] = ev[gi];
                        assign od[gi+1] = od[gi] + pp[gi];
                    end
                end
                assign p = ev[WIDTH] + od[WIDTH];
            end
        end
    endgenerate
endmodule

module mul_array_arbiter #(
    parameter int WIDTH        = 8,
    parameter bit BEHAVIORAL   = 1'b0,
    parameter bit RIPPLE_CARRY = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req0_signed,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic               req1_signed,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_result
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic                 rr_ptr_reg, rr_ptr_next;
    logic                 rsp_id_reg, rsp_id_next;
    logic [2*WIDTH-1:0]   rsp_result_reg, rsp_result_next;

    logic                 can_issue, grant0, grant1, grant_any;
    logic [WIDTH-1:0]     op_a, op_b, mul_a, mul_b;
    logic [2*WIDTH-1:0]   mul_p, product;

    // Slot is free or being drained this cycle; nothing is granted in reset.
    assign can_issue = !rst && ((state_reg == EMPTY) || rsp_ready);
    assign grant0    = can_issue && req0_valid && (!req1_valid || !rr_ptr_reg);
    assign grant1    = can_issue && req1_valid && (!req0_valid ||  rr_ptr_reg);
    assign grant_any = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign op_a = grant1 ? req1_a : req0_a;
    assign op_b = grant1 ? req1_b : req0_b;

`ifdef MUL_ARB_SIGNED_EN
    logic op_signed, neg_a, neg_b;
    assign op_signed = grant1 ? req1_signed : req0_signed;
    assign neg_a     = op_signed && op_a[WIDTH-1];
    assign neg_b     = op_signed && op_b[WIDTH-1];
    // Magnitudes: the most-negative value maps to its unsigned pattern, which is exact.
    assign mul_a     = neg_a ? (~op_a + WIDTH'(1)) : op_a;
    assign mul_b     = neg_b ? (~op_b + WIDTH'(1)) : op_b;
    assign product   = (neg_a ^ neg_b) ? (~mul_p + (2*WIDTH)'(1)) : mul_p;
`else
    logic unused_signed;
    assign unused_signed = req0_signed ^ req1_signed;
    assign mul_a         = op_a;
    assign mul_b         = op_b;
    assign product       = mul_p;
`endif

    mul_array #(
        .WIDTH        (WIDTH),
        .BEHAVIORAL   (BEHAVIORAL),
        .RIPPLE_CARRY (RIPPLE_CARRY)
    ) u_mul_array (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Next-state: capture on grant, drain when consumed with nothing new.
    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        if (grant_any) begin
            state_next      = FULL;
            rr_ptr_next     = !grant1;
            rsp_id_next     = grant1;
            rsp_result_next = product;
        end else if (rsp_ready) begin
            state_next = EMPTY;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= EMPTY;
            rr_ptr_reg     <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
        end
    end

    assign rsp_valid  = (state_reg == FULL);
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
endmodule

// File: tb/tb_mul_array_arbiter.sv
// Directed testbench for mul_array_arbiter (WIDTH=8). Expected signed
// results follow MUL_ARB_SIGNED_EN when it is defined for the build.
module tb_mul_array_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_signed;
    logic [7:0]  req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_signed;
    logic [7:0]  req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_array_arbiter #(.WIDTH(8), .BEHAVIORAL(1'b0), .RIPPLE_CARRY(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_signed (req0_signed),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_signed (req1_signed),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result)
    );

    // Advance past the next rising edge; inputs and samples happen here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_signed = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_signed = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rsp_ready = 1;
        rst = 1;
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
        end
        step();
        step();
        rst = 0;
        idle_inputs();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 16'h0000 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b id=%b res=%h want 0 0 0000", rsp_valid, rsp_id, rsp_result);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
        end
        // rr_ptr=0 after reset: contention goes to port 0.
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_rr_ptr: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        idle_inputs();
        $display("test_reset done");
    endtask

    task automatic test_single();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 8'hFF; req0_b = 8'hFF;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'hFE01) begin
            errors++;
            $display("FAIL single_result: got v=%b id=%b res=%h want 1 0 fe01", rsp_valid, rsp_id, rsp_result);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 16'hFE01 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got v=%b id=%b res=%h want 0 0 fe01", rsp_valid, rsp_id, rsp_result);
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        logic        exp_id;
        logic [15:0] exp_res;
        do_reset();
        rsp_ready = 1;
        exp_id = 0;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req0_a = 8'(i + 1); req0_b = 8'd10;
            req1_valid = 1; req1_a = 8'(i + 2); req1_b = 8'd20;
            #1;
            checks++;
            if (req0_ready !== (exp_id == 1'b0) || req1_ready !== (exp_id == 1'b1)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got r0=%b r1=%b want port %0d", i, req0_ready, req1_ready, exp_id);
            end
            exp_res = (exp_id == 1'b0) ? 16'((i + 1) * 10) : 16'((i + 2) * 20);
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== exp_res) begin
                errors++;
                $display("FAIL rr_result[%0d]: got v=%b id=%b res=%h want 1 %b %h", i, rsp_valid, rsp_id, rsp_result, exp_id, exp_res);
            end
            exp_id = ~exp_id;
        end
        idle_inputs();
        step();
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        // rr_ptr is 0 here (last grant went to port 1).
        rsp_ready = 1;
        req0_valid = 1; req0_a = 8'd48; req0_b = 8'd64;
        step();
        rsp_ready = 0;
        req1_valid = 1; req1_a = 8'd7; req1_b = 8'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'h0C00 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%b res=%h r0=%b r1=%b want 1 0 0c00 0 0",
                         i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready);
            end
            step();
        end
        rsp_ready = 1;
        req0_valid = 0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got r1=%b want 1", req1_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'h003F) begin
            errors++;
            $display("FAIL bp_replace: got v=%b id=%b res=%h want 1 1 003f", rsp_valid, rsp_id, rsp_result);
        end
        step();
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid();
        // Grant port 0 so rr_ptr becomes 1, then hold FULL.
        rsp_ready = 1;
        req0_valid = 1; req0_a = 8'd12; req0_b = 8'd12;
        step();
        rsp_ready = 0;
        req1_valid = 1; req1_a = 8'd3; req1_b = 8'd3;
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 16'h0000 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: got v=%b id=%b res=%h want 0 0 0000", rsp_valid, rsp_id, rsp_result);
        end
        rsp_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rr: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        idle_inputs();
        $display("test_reset_mid done");
    endtask

    task automatic test_signed();
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic        vs [4];
        logic        vp [4];
        logic [15:0] ve [4];
        va = '{8'hFD, 8'hFD, 8'h80, 8'h05};
        vb = '{8'h05, 8'h05, 8'h80, 8'hFD};
        vs = '{1'b1, 1'b0, 1'b1, 1'b1};
        vp = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef MUL_ARB_SIGNED_EN
        ve = '{16'hFFF1, 16'h04F1, 16'h4000, 16'hFFF1};
`else
        ve = '{16'h04F1, 16'h04F1, 16'h4000, 16'h04F1};
`endif
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (vp[i]) begin
                req1_valid = 1; req1_a = va[i]; req1_b = vb[i]; req1_signed = vs[i];
            end else begin
                req0_valid = 1; req0_a = va[i]; req0_b = vb[i]; req0_signed = vs[i];
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== vp[i] || rsp_result !== ve[i]) begin
                errors++;
                $display("FAIL signed[%0d]: got v=%b id=%b res=%h want 1 %b %h", i, rsp_valid, rsp_id, rsp_result, vp[i], ve[i]);
            end
        end
        idle_inputs();
        step();
        $display("test_signed done");
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        rsp_ready = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_signed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
